uart_tx_param: RTL and testbench

//  Parametrised UART transmitter with a small input FIFO and valid/ready input

---
 rtl/uart_tx_param.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with an input FIFO and valid/ready intake.
// Frames are start, DATA_BITS data bits sent LSB first, an optional parity
// bit, then STOP_BITS stop bits. Every bit lasts CLK_DIV clk cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | line high, waiting for a queued word
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only reached when PARITY != 0)
// S_STOP   | stop bit(s) high; pops the next word back-to-back
//
// line_tx is registered from the current state, timer and shift register, so
// the line lags the FSM by one cycle. The frame timing is unchanged; only the
// start of the frame moves to two edges after the push.
module uart_tx_param #(
  parameter int CLK_DIV    = 2500,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        line_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TMR_LAST  = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state, state_nxt;
  logic [TW-1:0]          timer;
  logic [BW-1:0]          bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   line_nxt;
  logic                   push, pop, fifo_empty, bit_end;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]   fifo_head;

  assign tx_ready   = (fifo_count != FIFO_FULL);
  assign push       = tx_valid & tx_ready;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = mem[rd_ptr];
  assign bit_end    = (timer == TMR_LAST);
  assign busy       = (state != S_IDLE) | !fifo_empty;

  // FIFO storage; data needs no reset because fifo_count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; a push and pop in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state and bit counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Next-state logic; pops happen from IDLE or at the very end of STOP.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    pop         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt   = S_STOP;
          bit_cnt_nxt = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_nxt = '0;
            if (!fifo_empty) begin
              pop       = 1'b1;
              state_nxt = S_START;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit timer: held at 0 in IDLE so START always begins a full bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           timer <= '0;
    else if (state == S_IDLE || bit_end) timer <= '0;
    else                               timer <= timer + TW'(1);
  end

  // Shift register and parity are captured together when a word is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (pop) begin
      shift_q <= fifo_head;
      par_q   <= (PARITY == 1) ? ~(^fifo_head) : (^fifo_head);
    end else if (state == S_DATA && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Line level for the current bit, derived only from registered state.
  always_comb begin
    line_nxt = 1'b1;
    case (state)
      S_START:  line_nxt = 1'b0;
      S_DATA:   line_nxt = shift_q[0];
      S_PARITY: line_nxt = par_q;
      default:  line_nxt = 1'b1;
    endcase
  end

  // Registered serial output, forced idle-high by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_tx <= 1'b1;
    else     line_tx <= line_nxt;
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: three transmitter instances (8N1, 8E1, 8O2) at CLK_DIV=4.
// Expected waveforms are built from the frame rules; a line decoder on the
// 8N1 instance recovers bytes and compares them with the accepted-word queue.
module tb_uart_tx_param;

  localparam int CDIV    = 4;
  localparam int FRAME_A = 10 * CDIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  int         sel;

  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       line_a, line_b, line_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic       line_mon, ready_mon, busy_mon;
  logic [2:0] cnt_mon;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  int         rx_t[$];
  bit         mon_en   = 1'b0;
  bit         dec_busy = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign valid_a = tx_valid && (sel == 0);
  assign valid_b = tx_valid && (sel == 1);
  assign valid_c = tx_valid && (sel == 2);

  always_comb begin
    line_mon  = line_a;
    ready_mon = ready_a;
    busy_mon  = busy_a;
    cnt_mon   = cnt_a;
    case (sel)
      1: begin line_mon = line_b; ready_mon = ready_b; busy_mon = busy_b; cnt_mon = cnt_b; end
      2: begin line_mon = line_c; ready_mon = ready_c; busy_mon = busy_c; cnt_mon = cnt_c; end
      default: ;
    endcase
  end

  uart_tx_param #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_a), .tx_ready(ready_a),
    .line_tx(line_a), .busy(busy_a), .fifo_count(cnt_a));

  uart_tx_param #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_b), .tx_ready(ready_b),
    .line_tx(line_b), .busy(busy_b), .fifo_count(cnt_b));

  uart_tx_param #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_c (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_c), .tx_ready(ready_c),
    .line_tx(line_c), .busy(busy_c), .fifo_count(cnt_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Single push with the selected instance expected to be ready; returns at
  // the negedge after the accepting edge.
  task automatic push_word(input logic [7:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    chk("push_ready", 32'(ready_mon), 32'(1));
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Expected frame built from the framing rules, compared every cycle.
  task automatic expect_frame(input logic [7:0] w, input int par, input int stops, input string tag);
    logic bits[$];
    int   ones;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    if (par != 0) begin
      ones = $countones(w);
      if (par == 1) bits.push_back((ones % 2) == 0);
      else          bits.push_back((ones % 2) == 1);
    end
    for (int s = 0; s < stops; s++) bits.push_back(1'b1);
    foreach (bits[b]) begin
      repeat (CDIV) begin
        @(negedge clk);
        chk(tag, 32'(line_mon), 32'(bits[b]));
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || dec_busy) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 32'(exp_q.size()), 32'(0));
  endtask

  // Line decoder for the 8N1 instance: samples every cycle of the frame.
  initial begin
    logic       s[FRAME_A];
    logic [7:0] d;
    bit         ok;
    int         t0;
    forever begin
      @(negedge clk);
      if (mon_en && line_a === 1'b0) begin
        dec_busy = 1'b1;
        t0       = cyc;
        s[0]     = line_a;
        for (int k = 1; k < FRAME_A; k++) begin
          @(negedge clk);
          s[k] = line_a;
        end
        ok = 1'b1;
        for (int b = 0; b < 10; b++)
          for (int c = 1; c < CDIV; c++)
            if (s[b*CDIV+c] !== s[b*CDIV]) ok = 1'b0;
        if (s[9*CDIV] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = s[(i+1)*CDIV];
        rx_t.push_back(t0);
        chk("rx_shape", 32'(ok), 32'(1));
        chk("rx_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) chk("rx_data", 32'(d), 32'(exp_q.pop_front()));
        dec_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w3[6];
    int         acc[6];
    int         i, guard, n_pushed;
    logic       r, v;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(line_a), 32'(1));
    chk("rst_ready", 32'(ready_a), 32'(1));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_count", 32'(cnt_a), 32'(0));
    chk("rst_line_b", 32'(line_b), 32'(1));
    chk("rst_line_c", 32'(line_c), 32'(1));
    rst = 1'b0;
    @(negedge clk);

    // 8N1 single frame with latency and busy checks
    sel = 0;
    push_word(8'h47);
    chk("t1_busy_queued", 32'(busy_mon), 32'(1));
    chk("t1_count_queued", 32'(cnt_mon), 32'(1));
    @(negedge clk);
    chk("t1_pre_start", 32'(line_mon), 32'(1));
    expect_frame(8'h47, 0, 1, "t1_frame");
    @(negedge clk);
    chk("t1_idle_line", 32'(line_mon), 32'(1));
    chk("t1_idle_busy", 32'(busy_mon), 32'(0));

    // even parity, one stop bit (44 cycles)
    sel = 1;
    push_word(8'h30);
    @(negedge clk);
    chk("t2e_pre_start", 32'(line_mon), 32'(1));
    expect_frame(8'h30, 2, 1, "t2_even_frame");
    @(negedge clk);
    chk("t2e_idle", 32'(line_mon), 32'(1));

    // odd parity, two stop bits
    sel = 2;
    push_word(8'h30);
    @(negedge clk);
    chk("t2o_pre_start", 32'(line_mon), 32'(1));
    expect_frame(8'h30, 1, 2, "t2_odd_frame");
    @(negedge clk);

    // two stop bits then immediate next start
    push_word(8'hFF);
    push_word(8'h00);
    expect_frame(8'hFF, 1, 2, "t4_frame_ff");
    expect_frame(8'h00, 1, 2, "t4_frame_00");
    @(negedge clk);
    chk("t4_idle_line", 32'(line_mon), 32'(1));
    chk("t4_idle_busy", 32'(busy_mon), 32'(0));

    // burst with tx_valid held high into a full FIFO
    sel = 0;
    rx_t.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w3[k]  = 8'($urandom);
      acc[k] = 0;
    end
    i = 0; guard = 0;
    tx_valid = 1'b1;
    while (i < 6 && guard < 200) begin
      tx_data = w3[i];
      r       = ready_mon;
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (r) begin
        acc[i] = cyc;
        exp_q.push_back(w3[i]);
        i++;
        if (i == 5) begin
          chk("t3_full_count", 32'(cnt_mon), 32'(4));
          chk("t3_full_ready", 32'(ready_mon), 32'(0));
        end
      end
    end
    tx_valid = 1'b0;
    chk("t3_all_accepted", 32'(i), 32'(6));
    chk("t3_burst_span", 32'(acc[4] - acc[0]), 32'(4));
    chk("t3_sixth_after_pop", 32'(acc[5] - acc[0]), 32'(2 + FRAME_A));
    wait_drain("t3_drain");
    chk("t3_frames", 32'(rx_t.size()), 32'(6));
    if (rx_t.size() == 6) begin
      chk("t3_first_start", 32'(rx_t[0] - acc[0]), 32'(2));
      for (int k = 1; k < 6; k++) chk("t3_gap", 32'(rx_t[k] - rx_t[k-1]), 32'(FRAME_A));
    end
    @(negedge clk);
    chk("t3_idle_busy", 32'(busy_mon), 32'(0));
    mon_en = 1'b0;

    // reset in the middle of a frame with two words queued
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (12) @(negedge clk);
    chk("t5_queued", 32'(cnt_mon), 32'(2));
    chk("t5_busy_before", 32'(busy_mon), 32'(1));
    rst = 1'b1;
    #1;
    chk("t5_rst_line", 32'(line_mon), 32'(1));
    chk("t5_rst_count", 32'(cnt_mon), 32'(0));
    chk("t5_rst_busy", 32'(busy_mon), 32'(0));
    chk("t5_rst_ready", 32'(ready_mon), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_word(8'hA5);
    @(negedge clk);
    chk("t5_pre_start", 32'(line_mon), 32'(1));
    expect_frame(8'hA5, 0, 1, "t5_frame");
    @(negedge clk);
    chk("t5_idle_busy", 32'(busy_mon), 32'(0));

    // random traffic against the decoded byte stream
    rx_t.delete();
    mon_en   = 1'b1;
    n_pushed = 0;
    for (int k = 0; k < 800; k++) begin
      if (((k / 200) % 2) == 0) v = ($urandom_range(0, 3) != 0);
      else                      v = ($urandom_range(0, 39) == 0);
      tx_valid = v;
      tx_data  = 8'($urandom);
      r        = ready_mon;
      @(posedge clk);
      if (v && r) begin
        exp_q.push_back(tx_data);
        n_pushed++;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_drain("t6_drain");
    chk("t6_frames", 32'(rx_t.size()), 32'(n_pushed));
    @(negedge clk);
    chk("t6_end_busy", 32'(busy_mon), 32'(0));
    chk("t6_end_count", 32'(cnt_mon), 32'(0));
    chk("t6_end_line", 32'(line_mon), 32'(1));
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
